// File: rtl/riscv_pkg.sv
// Core-wide architectural constants shared by the RVFI record and the monitor.
package riscv;

    localparam int unsigned XLEN = 64;

endpackage

// File: rtl/rvfi_monitor_pkg.sv
// Shared types and encodings for the RVFI commit monitor.
package rvfi_monitor_pkg;

    // Termination cause reported on cause_o.
    typedef enum logic [2:0] {
        NONE    = 3'd0,
        TOHOST  = 3'd1,
        TIMEOUT = 3'd2,
        HANG    = 3'd3
    } term_cause_e;

    // Monitor FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mon_state_e;

    // Uncompressed store encoding.
    localparam logic [6:0] STORE_OPCODE = 7'b0100011;
    localparam logic [2:0] FUNCT3_SW    = 3'b010;
    localparam logic [2:0] FUNCT3_SD    = 3'b011;

    // Compressed quadrant-0 store encodings.
    localparam logic [1:0] C_QUADRANT0  = 2'b00;
    localparam logic [2:0] C_SW_FUNCT3  = 3'b110;
    localparam logic [2:0] C_SD_FUNCT3  = 3'b111;

endpackage

// File: rtl/rvfi_pkg.sv
// Reduced RVFI commit record: only the fields the commit monitor looks at.
package rvfi_pkg;

    typedef struct packed {
        logic                       valid;
        logic                       trap;
        logic [31:0]                insn;
        logic [riscv::XLEN-1:0]     pc_rdata;
        logic [riscv::XLEN-1:0]     mem_addr;
        logic [riscv::XLEN/8-1:0]   mem_wmask;
        logic [riscv::XLEN-1:0]     mem_wdata;
    } rvfi_instr_t;

endpackage

// File: rtl/rvfi_store_decode.sv
// Recognises word/doubleword stores (SW/SD and C.SW/C.SD) from a committed insn.
module rvfi_store_decode
    import rvfi_monitor_pkg::*;
#(
    parameter int unsigned XLEN = riscv::XLEN
) (
    input  logic [31:0] insn,
    output logic        is_store_wd
);

    logic is_sw_sd;
    logic is_c_store;

    // Decode both encodings; C.SD only exists on RV64 (on RV32 that slot is C.FSW).
    always_comb begin
        is_sw_sd   = (insn[6:0] == STORE_OPCODE) &&
                     ((insn[14:12] == FUNCT3_SW) || (insn[14:12] == FUNCT3_SD));
        is_c_store = (insn[1:0] == C_QUADRANT0) &&
                     ((insn[15:13] == C_SW_FUNCT3) ||
                      ((XLEN == 64) && (insn[15:13] == C_SD_FUNCT3)));
        is_store_wd = is_sw_sd || is_c_store;
    end

    // Register and immediate fields play no part in recognising the store.
    logic unused_insn_bits;
    assign unused_insn_bits = ^{insn[31:16], insn[11:7]};

endmodule

// File: rtl/rvfi_commit_monitor.sv
// Watches RVFI commit ports for a tohost result store and runs timeout/hang watchdogs.
module rvfi_commit_monitor
    import rvfi_monitor_pkg::*;
#(
    parameter int unsigned NR_COMMIT_PORTS = 2,
    parameter int unsigned XLEN            = riscv::XLEN,
    parameter int unsigned CNT_W           = 64,
    parameter int unsigned TIMEOUT_CYCLES  = 2000000,
    parameter int unsigned HANG_CYCLES     = 10000
) (
    input  logic                                        clk_i,
    input  logic                                        rst_ni,
    input  rvfi_pkg::rvfi_instr_t [NR_COMMIT_PORTS-1:0] rvfi_i,
    input  logic                                        arm_i,
    input  logic [XLEN-1:0]                             tohost_addr_i,
    output logic                                        done_o,
    output term_cause_e                                 cause_o,
    output logic [XLEN-1:0]                             exit_code_o,
    output logic                                        pass_o,
    output logic [XLEN-1:0]                             term_pc_o,
    output logic [CNT_W-1:0]                            cycle_cnt_o,
    output logic [CNT_W-1:0]                            retire_cnt_o
);

    localparam int unsigned NP     = NR_COMMIT_PORTS;
    localparam int unsigned HANG_W = 32;

    mon_state_e                 state_q, state_d;
    term_cause_e                cause_q, cause_d;
    logic [XLEN-1:0]            exit_code_q, exit_code_d;
    logic [XLEN-1:0]            term_pc_q, term_pc_d;
    logic [CNT_W-1:0]           cycle_cnt_q, retire_cnt_q;
    logic [HANG_W-1:0]          quiet_q;
    logic [NP-1:0]              pend_vld_q;
    logic [NP-1:0][XLEN-1:0]    pend_data_q;

    logic                       active;
    logic [NP-1:0]              commit;
    logic [NP-1:0]              is_store;
    logic [NP-1:0]              addr_hit;
    logic [NP-1:0]              tohost_evt;
    logic [NP-1:0][XLEN-1:0]    evt_data;
    logic [NP-1:0]              unused_trap;

    // Counting and detection only happen while armed in RUN.
    assign active = (state_q == ST_RUN) && arm_i;

    for (genvar i = 0; i < NP; i++) begin : g_port
        rvfi_store_decode #(
            .XLEN (XLEN)
        ) u_store_decode (
            .insn        (rvfi_i[i].insn),
            .is_store_wd (is_store[i])
        );

        assign commit[i]   = rvfi_i[i].valid;
        assign addr_hit[i] = (tohost_addr_i != '0) &&
                             (rvfi_i[i].mem_addr == tohost_addr_i) &&
                             (|rvfi_i[i].mem_wmask) &&
                             (|rvfi_i[i].mem_wdata);
        // The current beat's data wins; otherwise fall back to an earlier mem-only beat.
        assign evt_data[i]   = addr_hit[i] ? rvfi_i[i].mem_wdata : pend_data_q[i];
        assign tohost_evt[i] = commit[i] && is_store[i] &&
                               (addr_hit[i] || pend_vld_q[i]) && evt_data[i][0];
        // A trap without valid never counts or terminates, so the flag is not needed.
        assign unused_trap[i] = rvfi_i[i].trap;
    end

    logic [2:0]        n_valid;
    logic              any_valid;
    logic [CNT_W:0]    retire_sum;
    logic [CNT_W-1:0]  retire_next;
    logic [CNT_W-1:0]  cycle_next;
    logic [HANG_W-1:0] quiet_next;
    logic              timeout_evt;
    logic              hang_evt;

    // Saturating next values for the statistics and watchdog counters.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        n_valid = '0;
        for (int i = 0; i < int'(NP); i++) begin
            // NOTE: blocking '=' is right here: the sum must accumulate within one evaluation.
            n_valid = n_valid + 3'(commit[i]);
        end
        any_valid   = |commit;
        retire_sum  = {1'b0, retire_cnt_q} + (CNT_W+1)'(n_valid);
        retire_next = retire_sum[CNT_W] ? '1 : retire_sum[CNT_W-1:0];
        cycle_next  = (cycle_cnt_q == '1) ? cycle_cnt_q : cycle_cnt_q + CNT_W'(1);
        if (any_valid) begin
            quiet_next = '0;
        end else begin
            quiet_next = (quiet_q == '1) ? quiet_q : quiet_q + HANG_W'(1);
        end
        timeout_evt = (TIMEOUT_CYCLES != 0) && (cycle_next == CNT_W'(TIMEOUT_CYCLES));
        hang_evt    = (HANG_CYCLES != 0) && (quiet_next == HANG_W'(HANG_CYCLES));
    end

    logic             win_vld;
    logic [XLEN-1:0]  win_data;
    logic [XLEN-1:0]  win_pc;

    // Pick the lowest-index port with a tohost event (descending scan, last hit wins).
    always_comb begin
        win_vld  = 1'b0;
        win_data = '0;
        win_pc   = '0;
        for (int i = int'(NP) - 1; i >= 0; i--) begin
            if (tohost_evt[i]) begin
                win_vld  = 1'b1;
                win_data = evt_data[i];
                win_pc   = rvfi_i[i].pc_rdata;
            end
        end
    end

    // Next state and termination record; tohost beats HANG, HANG beats TIMEOUT.
    always_comb begin
        state_d     = state_q;
        cause_d     = cause_q;
        exit_code_d = exit_code_q;
        term_pc_d   = term_pc_q;
        unique case (state_q)
            ST_IDLE: begin
                if (arm_i) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!arm_i) begin
                    state_d = ST_IDLE;
                end else if (win_vld) begin
                    state_d     = ST_DONE;
                    cause_d     = TOHOST;
                    exit_code_d = win_data >> 1;
                    term_pc_d   = win_pc;
                end else if (hang_evt) begin
                    state_d = ST_DONE;
                    cause_d = HANG;
                end else if (timeout_evt) begin
                    state_d = ST_DONE;
                    cause_d = TIMEOUT;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state and the latched termination record.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: non-blocking '<=' for all registered state so every flop samples pre-edge values.
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            cause_q     <= NONE;
            exit_code_q <= '0;
            term_pc_q   <= '0;
        end else begin
            state_q     <= state_d;
            cause_q     <= cause_d;
            exit_code_q <= exit_code_d;
            term_pc_q   <= term_pc_d;
        end
    end

    // Cycle, retire and no-retire counters advance only while armed in RUN.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cycle_cnt_q  <= '0;
            retire_cnt_q <= '0;
            quiet_q      <= '0;
        end else if (active) begin
            cycle_cnt_q  <= cycle_next;
            retire_cnt_q <= retire_next;
            quiet_q      <= quiet_next;
        end
    end

    // Remember tohost data seen before its valid beat; the valid beat consumes it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: the data regs are reset too, so a stale value can never surface as an exit code.
            pend_vld_q  <= '0;
            pend_data_q <= '0;
        end else if (active) begin
            for (int i = 0; i < int'(NP); i++) begin
                if (commit[i]) begin
                    pend_vld_q[i] <= 1'b0;
                end else if (addr_hit[i]) begin
                    pend_vld_q[i]  <= 1'b1;
                    pend_data_q[i] <= rvfi_i[i].mem_wdata;
                end
            end
        end
    end

    assign done_o       = (state_q == ST_DONE);
    assign cause_o      = cause_q;
    assign exit_code_o  = exit_code_q;
    assign term_pc_o    = term_pc_q;
    assign pass_o       = done_o && (cause_q == TOHOST) && (exit_code_q == '0);
    assign cycle_cnt_o  = cycle_cnt_q;
    assign retire_cnt_o = retire_cnt_q;

endmodule

// File: tb/tb_rvfi_commit_monitor.sv
// Directed and randomized checks of rvfi_commit_monitor against a behavioural model.
module tb_rvfi_commit_monitor;
    import rvfi_monitor_pkg::*;

    localparam int unsigned NP = 2;
    localparam int unsigned XL = riscv::XLEN;
    localparam int unsigned CW = 64;
    localparam int unsigned TO = 100;
    localparam int unsigned HG = 16;
    localparam logic [63:0] TOHOST_ADDR = 64'h0000_0000_8000_1000;

    localparam logic [31:0] I_SW   = 32'h0000_2023;
    localparam logic [31:0] I_SD   = 32'h0000_3023;
    localparam logic [31:0] I_CSW  = 32'h0000_C000;
    localparam logic [31:0] I_CSD  = 32'h0000_E000;
    localparam logic [31:0] I_ADDI = 32'h0000_0013;

    logic                           clk = 1'b0;
    logic                           rst_n;
    rvfi_pkg::rvfi_instr_t [NP-1:0] rvfi;
    logic                           arm;
    logic [XL-1:0]                  tohost_addr;
    logic                           done;
    logic [2:0]                     cause;
    logic [XL-1:0]                  exit_code;
    logic                           pass;
    logic [XL-1:0]                  term_pc;
    logic [CW-1:0]                  cycle_cnt;
    logic [CW-1:0]                  retire_cnt;

    int    n_checks = 0;
    int    n_fail   = 0;
    string scen     = "reset";

    always #5 clk = ~clk;

    rvfi_commit_monitor #(
        .NR_COMMIT_PORTS (NP),
        .XLEN            (XL),
        .CNT_W           (CW),
        .TIMEOUT_CYCLES  (TO),
        .HANG_CYCLES     (HG)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .rvfi_i        (rvfi),
        .arm_i         (arm),
        .tohost_addr_i (tohost_addr),
        .done_o        (done),
        .cause_o       (cause),
        .exit_code_o   (exit_code),
        .pass_o        (pass),
        .term_pc_o     (term_pc),
        .cycle_cnt_o   (cycle_cnt),
        .retire_cnt_o  (retire_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s/%s: got 0x%0h, expected 0x%0h at %0t", scen, tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    int              m_phase;     // 0 disarmed, 1 running, 2 finished
    longint unsigned m_cycles;
    longint unsigned m_retired;
    int              m_quiet;
    bit              m_pend     [NP];
    logic [63:0]     m_pend_val [NP];
    int              m_cause;
    logic [63:0]     m_exit;
    logic [63:0]     m_pc;

    function automatic bit ref_is_store(input logic [31:0] i);
        return (i ==? 32'b?????????????????_010_?????_0100011) ||
               (i ==? 32'b?????????????????_011_?????_0100011) ||
               (i[15:0] ==? 16'b110_???????????_00) ||
               ((XL == 64) && (i[15:0] ==? 16'b111_???????????_00));
    endfunction

    task automatic model_reset();
        m_phase = 0; m_cycles = 0; m_retired = 0; m_quiet = 0;
        m_cause = 0; m_exit = '0; m_pc = '0;
        for (int p = 0; p < int'(NP); p++) begin
            m_pend[p] = 1'b0;
            m_pend_val[p] = '0;
        end
    endtask

    // Applies one clock edge worth of the rules to the inputs currently driven.
    task automatic model_step();
        int          winner;
        int          nval;
        logic [63:0] wval;
        if (m_phase == 0) begin
            if (arm) m_phase = 1;
            return;
        end
        if (m_phase == 2) return;
        if (!arm) begin
            m_phase = 0;
            return;
        end
        winner = -1; nval = 0; wval = '0;
        for (int p = 0; p < int'(NP); p++) begin
            bit          hit;
            bit          have;
            logic [63:0] val;
            hit  = (tohost_addr != 0) && (rvfi[p].mem_addr == tohost_addr) &&
                   (rvfi[p].mem_wmask != 0) && (rvfi[p].mem_wdata != 0);
            have = hit || m_pend[p];
            val  = hit ? rvfi[p].mem_wdata : m_pend_val[p];
            if (rvfi[p].valid && ref_is_store(rvfi[p].insn) && have && val[0] && winner < 0) begin
                winner = p;
                wval   = val;
            end
            if (rvfi[p].valid) begin
                nval++;
                m_pend[p] = 1'b0;
            end else if (hit) begin
                m_pend[p]     = 1'b1;
                m_pend_val[p] = rvfi[p].mem_wdata;
            end
        end
        m_cycles++;
        m_retired += longint'(nval);
        m_quiet = (nval > 0) ? 0 : m_quiet + 1;
        if (winner >= 0) begin
            m_phase = 2; m_cause = 1; m_exit = wval >> 1; m_pc = rvfi[winner].pc_rdata;
        end else if (m_quiet == int'(HG)) begin
            m_phase = 2; m_cause = 3;
        end else if (m_cycles == longint'(TO)) begin
            m_phase = 2; m_cause = 2;
        end
    endtask

    task automatic check_all();
        check("done",   64'(done),       64'(m_phase == 2));
        check("cause",  64'(cause),      64'(m_cause));
        check("exit",   exit_code,       m_exit);
        check("pass",   64'(pass),       64'(m_phase == 2 && m_cause == 1 && m_exit == 0));
        check("pc",     term_pc,         m_pc);
        check("cycles", cycle_cnt,       m_cycles);
        check("retire", retire_cnt,      m_retired);
    endtask

    // ---------------- stimulus helpers ----------------
    function automatic rvfi_pkg::rvfi_instr_t beat(input bit v, input logic [31:0] insn,
                                                   input logic [63:0] pc, input logic [63:0] addr,
                                                   input logic [7:0] wmask, input logic [63:0] wdata);
        rvfi_pkg::rvfi_instr_t b;
        b = '0;
        b.valid = v; b.insn = insn; b.pc_rdata = pc;
        b.mem_addr = addr; b.mem_wmask = wmask; b.mem_wdata = wdata;
        return b;
    endfunction

    function automatic rvfi_pkg::rvfi_instr_t rand_beat(input int vprob);
        rvfi_pkg::rvfi_instr_t b;
        logic [31:0] insn;
        b = '0;
        b.valid = ($urandom_range(0, 99) < vprob);
        b.trap  = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 5))
            0: insn = I_SW;
            1: insn = I_SD;
            2: insn = I_CSW;
            3: insn = I_CSD;
            4: insn = I_ADDI;
            default: insn = $urandom;
        endcase
        b.insn      = insn;
        b.pc_rdata  = {$urandom, $urandom};
        b.mem_addr  = ($urandom_range(0, 1) == 0) ? TOHOST_ADDR : {32'h0, $urandom};
        b.mem_wmask = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
        case ($urandom_range(0, 3))
            0: b.mem_wdata = '0;
            1: b.mem_wdata = 64'h1;
            2: b.mem_wdata = 64'($urandom_range(0, 255));
            default: b.mem_wdata = {$urandom, $urandom};
        endcase
        return b;
    endfunction

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        arm = 1'b0; tohost_addr = '0; rvfi = '0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int k;
        rst_n = 1'b0; arm = 1'b0; tohost_addr = '0; rvfi = '0;

        // SD to tohost with value 1 on port 0.
        scen = "sd_pass";
        do_reset();
        tohost_addr = TOHOST_ADDR; arm = 1'b1;
        step();
        rvfi[0] = beat(1'b1, I_SD, 64'hFFFF_FFFF_8000_0040, TOHOST_ADDR, 8'hFF, 64'h1);
        step();
        check("sd_done", 64'(done), 64'h1);
        check("sd_cause", 64'(cause), 64'(TOHOST));
        check("sd_exit", exit_code, 64'h0);
        check("sd_pass", 64'(pass), 64'h1);
        check("sd_pc", term_pc, 64'hFFFF_FFFF_8000_0040);
        // DONE is sticky: a later tohost store must not change the record.
        rvfi[0] = beat(1'b1, I_SD, 64'h1234, TOHOST_ADDR, 8'hFF, 64'h5);
        step(); step();
        check("sd_sticky", exit_code, 64'h0);

        // C.SW whose store data arrives one beat ahead of the valid beat.
        scen = "csw_early";
        do_reset();
        tohost_addr = TOHOST_ADDR; arm = 1'b1;
        step();
        rvfi[0] = beat(1'b0, 32'h0, 64'h0, TOHOST_ADDR, 8'h0F, 64'h55);
        step();
        check("csw_not_yet", 64'(done), 64'h0);
        rvfi[0] = beat(1'b1, I_CSW, 64'h8000_0100, 64'h0, 8'h00, 64'h0);
        step();
        rvfi = '0;
        check("csw_exit", exit_code, 64'h2A);
        check("csw_pass", 64'(pass), 64'h0);
        check("csw_pc", term_pc, 64'h8000_0100);

        // Two tohost events in one cycle: port 0 wins.
        scen = "dual";
        do_reset();
        tohost_addr = TOHOST_ADDR; arm = 1'b1;
        step();
        rvfi[0] = beat(1'b1, I_SD, 64'h8000_0200, TOHOST_ADDR, 8'hFF, 64'h7);
        rvfi[1] = beat(1'b1, I_SW, 64'h8000_0204, TOHOST_ADDR, 8'h0F, 64'h3);
        step();
        rvfi = '0;
        check("dual_exit", exit_code, 64'h3);
        check("dual_pc", term_pc, 64'h8000_0200);
        check("dual_retire", retire_cnt, 64'h2);

        // Timeout with tohost detection disabled and steady commits.
        scen = "timeout";
        do_reset();
        arm = 1'b1;
        step();
        k = 0;
        while (!done && k < 120) begin
            rvfi[0] = beat(1'b1, I_ADDI, 64'h8000_0000 + 64'(4 * k), 64'h0, 8'h0, 64'h0);
            step();
            k++;
        end
        rvfi = '0;
        check("to_latency", 64'(k), 64'd100);
        check("to_cause", 64'(cause), 64'(TIMEOUT));
        check("to_cycles", cycle_cnt, 64'd100);
        check("to_exit", exit_code, 64'h0);

        // Hang after five retires; a trap-only beat must not postpone it.
        scen = "hang";
        do_reset();
        tohost_addr = TOHOST_ADDR; arm = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            rvfi[0] = beat(1'b1, I_ADDI, 64'h100 + 64'(4 * i), 64'h0, 8'h0, 64'h0);
            step();
        end
        k = 0;
        while (!done && k < 40) begin
            rvfi = '0;
            if (k == 3) rvfi[0].trap = 1'b1;
            step();
            k++;
        end
        check("hang_latency", 64'(k), 64'd16);
        check("hang_cause", 64'(cause), 64'(HANG));
        check("hang_retire", retire_cnt, 64'd5);

        // Disarm for ten cycles, re-arm, finish, then reset asynchronously.
        scen = "disarm";
        do_reset();
        tohost_addr = TOHOST_ADDR; arm = 1'b1;
        step();
        for (int i = 0; i < 8; i++) begin
            rvfi[0] = beat(1'b1, I_ADDI, 64'h200, 64'h0, 8'h0, 64'h0);
            step();
        end
        arm = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("hold_cycles", cycle_cnt, 64'd8);
        check("hold_retire", retire_cnt, 64'd8);
        arm = 1'b1;
        step();
        for (int i = 0; i < 3; i++) step();
        rvfi[0] = '0;
        rvfi[1] = beat(1'b1, I_SW, 64'h8000_0300, TOHOST_ADDR, 8'h0F, 64'h9);
        step();
        rvfi = '0;
        check("rearm_cycles", cycle_cnt, 64'd12);
        check("rearm_retire", retire_cnt, 64'd12);
        check("rearm_exit", exit_code, 64'h4);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        check("async_done", 64'(done), 64'h0);
        check("async_cycles", cycle_cnt, 64'h0);
        #3;
        rst_n = 1'b1;

        // Randomized episodes against the model.
        for (int ep = 0; ep < 12; ep++) begin
            int vprob;
            int tail;
            scen = $sformatf("rand%0d", ep);
            do_reset();
            tohost_addr = ($urandom_range(0, 3) == 0) ? '0 : TOHOST_ADDR;
            vprob = (ep % 3 == 0) ? 10 : 70;
            arm   = 1'b1;
            tail  = 0;
            for (int c = 0; c < 140 && tail < 4; c++) begin
                if ($urandom_range(0, 19) == 0) arm = ~arm;
                for (int p = 0; p < int'(NP); p++) rvfi[p] = rand_beat(vprob);
                step();
                if (m_phase == 2) tail++;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
